t_ff_bank: RTL and testbench
============================

// Module: t_ff_bank
// PURPOSE
//  Parametrised bank of WIDTH edge-triggered T flip-flops with a common clock and a
//  synchronous active-high reset. This is the clocked successor of the single-bit T latch.
//  Each cycle, an opcode selects one of four operations: per-bit toggle, parallel load,
//  set-all or clear-all.
//  Chain mode turns the toggle operation into a synchronous binary up-counter built from
//  T stages, with a wrap pulse. Used for divider chains and toggle-controlled status flags.
// PARAMETERS
//  WIDTH     8    number of T stages (>=1)
//  RESET_VAL 0    value loaded into q on reset (WIDTH bits)
//  CHAIN_EN  1    1: chain input honoured; 0: chain input ignored (treated as 0)
// PORTS
//  clk      in   1      clock; all state changes on rising edge
//  rst      in   1      synchronous reset, active-high, highest priority
//  en       in   1      operation enable; 0 = hold
//  op       in   2      00 TOGGLE, 01 LOAD, 10 SET, 11 CLEAR
//  chain    in   1      1 = TOGGLE behaves as carry-chained counter
//  t        in   WIDTH  per-bit toggle request (TOGGLE only)
//  d        in   WIDTH  parallel load data (LOAD only)
//  q        out  WIDTH  flip-flop outputs
//  changed  out  WIDTH  registered: bits of q that changed on the last edge
//  wrap     out  1      registered: 1-cycle pulse when chained count rolled over
// BEHAVIOUR
//  - All outputs are registered. Latency is one clock: inputs sampled at edge N appear on
//    q, changed and wrap after edge N.
//  - Reset (rst=1 at edge): q<=RESET_VAL, changed<=0, wrap<=0. Reset overrides en, op,
//    t, d and chain.
//    Mid-operation reset discards any pending operation. No partial update.
//  - en=0: q holds; changed<=0; wrap<=0.
//  - en=1, op=TOGGLE, chain=0: q <= q ^ t. Bits with t=0 hold.
//  - en=1, op=TOGGLE, chain=1 (CHAIN_EN=1):
//      tog[0] = t[0]
//      tog[i] = t[i] & (&q[i-1:0])
//      q <= q ^ tog
//    With t all ones, this is q <= q+1 mod 2^WIDTH.
//    Carry depends only on q, not on t of lower bits.
//  - wrap <= 1 only when en=1, op=TOGGLE, the effective chain=1, q==all ones and
//    t==all ones (q -> 0). Otherwise wrap <= 0.
//  - en=1, op=LOAD: q <= d.   op=SET: q <= all ones.   op=CLEAR: q <= 0.
//    The t and chain inputs are ignored for these ops.
//  - changed <= q_next ^ q_current on every non-reset edge. It is 0 when nothing changed,
//    e.g. LOAD of an identical value.
//  - CHAIN_EN=0: chain input forced to 0 internally; wrap is constant 0 after reset.
//  - WIDTH=1: chain mode reduces to a plain T-FF; wrap fires on the 1->0 toggle.
//  - No X propagation: q is fully defined after the first reset edge.
// TESTING
//  1) WIDTH=8, RESET_VAL=8'hA5.
//     Stimulus: rst=1 for 2 edges, then rst=0, en=0.
//     Required: q=8'hA5, changed=0, wrap=0; q holds 8'hA5 for 3 edges.
//  2) Start q=8'h0F, en=1, op=00, chain=0, t=8'h3C.
//     Required: q=8'h33, changed=8'h3C next cycle. Same t again gives q=8'h0F.
//  3) Start q=8'hFD, en=1, op=00, chain=1, t=8'hFF, held for 3 edges.
//     Required: q sequence FE, FF, 00, with wrap=1 only on the cycle q=00.
//  4) Chain mode, q=8'h07, t=8'hF7 (t[3]=0).
//     Required: q=8'h00 (bits 0-2 clear, bit 3 blocked), changed=8'h07, wrap=0.
//  5) LOAD d=8'h5A, then SET, then CLEAR, then LOAD d=8'h00.
//     Required: q=5A, FF, 00, 00; changed= (q_prev^5A), A5, FF, 00.
//  6) Counting in chain mode, q=8'h80.
//     Stimulus: assert rst together with op=LOAD, d=8'h11.
//     Required: q=RESET_VAL, changed=0, wrap=0; the load is not applied.

Source files
------------

// File: rtl/t_ff_bank.sv
// t_ff_bank: a bank of WIDTH edge-triggered T flip-flops.
// Every cycle an opcode selects toggle, parallel load, set-all or clear-all.
// In chain mode, toggle becomes a synchronous up-counter with a wrap pulse.
module t_ff_bank #(
   parameter int              WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit              CHAIN_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       op,
   input  logic             chain,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] changed,
   output logic             wrap
);

   localparam logic [1:0] OP_TOGGLE = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   // When chaining is compiled out, the chain input is ignored entirely.
   logic chain_eff;
   assign chain_eff = CHAIN_EN && chain;

   // carry[i] is high when all stages below i are set.
   // Each bit is computed directly from q, so there is no combinational loop through carry.
   logic [WIDTH-1:0] carry;
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi = gi + 1) begin : g_carry
         assign carry[gi] = &q[gi-1:0];
      end
   endgenerate

   // Toggle mask.
   // In chain mode, a stage toggles only when its own t is set and all lower q bits are set.
   // Lower t bits do not affect the carry.
   logic [WIDTH-1:0] tog;
   assign tog = chain_eff ? (t & carry) : t;

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   // Next-state selection from the opcode; en=0 holds q.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (en) begin
         case (op)
            OP_TOGGLE: begin
               q_next    = q ^ tog;
               wrap_next = chain_eff && (&q) && (&t);
            end
            OP_LOAD:  q_next = d;
            OP_SET:   q_next = '1;
            OP_CLEAR: q_next = '0;
            default:  q_next = q;
         endcase
      end
   end

   // Registered state and status.
   // Reset wins over everything and discards any pending operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= RESET_VAL;
         changed <= '0;
         wrap    <= 1'b0;
      end else begin
         q       <= q_next;
         changed <= q_next ^ q;
         wrap    <= wrap_next;
      end
   end

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed testbench for t_ff_bank (WIDTH=8, RESET_VAL=8'hA5, CHAIN_EN=1).
// Each step drives inputs, waits one edge, then checks q, changed and wrap
// against hand-computed values.
module tb_t_ff_bank;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] op;
   logic       chain;
   logic [7:0] t;
   logic [7:0] d;
   logic [7:0] q;
   logic [7:0] changed;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   t_ff_bank #(
      .WIDTH    (8),
      .RESET_VAL(8'hA5),
      .CHAIN_EN (1'b1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .op     (op),
      .chain  (chain),
      .t      (t),
      .d      (d),
      .q      (q),
      .changed(changed),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs, clock once, sample 1 ns after the edge, then check.
   task automatic step(input string tag,
                       input logic r, input logic e, input logic [1:0] o,
                       input logic c, input logic [7:0] tv, input logic [7:0] dv,
                       input logic [7:0] exp_q, input logic [7:0] exp_ch,
                       input logic exp_w);
      rst = r; en = e; op = o; chain = c; t = tv; d = dv;
      @(posedge clk);
      #1;

      checks++;
      assert (q === exp_q)
         else begin
            errors++;
            $error("FAIL %s q observed=%h expected=%h", tag, q, exp_q);
         end

      checks++;
      assert (changed === exp_ch)
         else begin
            errors++;
            $error("FAIL %s changed observed=%h expected=%h", tag, changed, exp_ch);
         end

      checks++;
      assert (wrap === exp_w)
         else begin
            errors++;
            $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, exp_w);
         end

      $display("step %-12s q=%h changed=%h wrap=%b", tag, q, changed, wrap);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; op = 2'b00; chain = 1'b0; t = 8'h00; d = 8'h00;

      //    tag            rst   en    op     chain t      d      q      changed wrap

      // 1) Reset for two edges, then hold with en=0 for three edges.
      step("rst0",        1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0);
      step("rst1",        1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0);
      step("hold0",       1'b0, 1'b0, 2'b00, 1'b0, 8'hFF, 8'h00, 8'hA5, 8'h00, 1'b0);
      step("hold1",       1'b0, 1'b0, 2'b10, 1'b1, 8'hFF, 8'h00, 8'hA5, 8'h00, 1'b0);
      step("hold2",       1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 8'h3C, 8'hA5, 8'h00, 1'b0);

      // 2) Per-bit toggle without chaining.
      step("ld0F",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h0F, 8'h0F, 8'hAA, 1'b0);
      step("tog3C_a",     1'b0, 1'b1, 2'b00, 1'b0, 8'h3C, 8'h00, 8'h33, 8'h3C, 1'b0);
      step("tog3C_b",     1'b0, 1'b1, 2'b00, 1'b0, 8'h3C, 8'h00, 8'h0F, 8'h3C, 1'b0);

      // 3) Chained count through rollover; wrap pulses only on the 00 cycle.
      step("ldFD",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'hFD, 8'hFD, 8'hF2, 1'b0);
      step("cnt_FE",      1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 8'h00, 8'hFE, 8'h03, 1'b0);
      step("cnt_FF",      1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h01, 1'b0);
      step("cnt_00",      1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1);
      step("post_wrap",   1'b0, 1'b0, 2'b00, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);

      // 4) Chain with t[3]=0: bits 0-2 clear, and the carry into bit 3 is blocked.
      step("ld07",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h07, 8'h07, 8'h07, 1'b0);
      step("chain_blk",   1'b0, 1'b1, 2'b00, 1'b1, 8'hF7, 8'h00, 8'h00, 8'h07, 1'b0);

      // Boundary: q all ones but t not all ones gives no wrap.
      step("ldFF",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      step("nowrap_t7F",  1'b0, 1'b1, 2'b00, 1'b1, 8'h7F, 8'h00, 8'h80, 8'h7F, 1'b0);

      // 5) LOAD, SET, CLEAR, then LOAD of an identical value.
      step("ld5A",        1'b0, 1'b1, 2'b01, 1'b1, 8'hFF, 8'h5A, 8'h5A, 8'hDA, 1'b0);
      step("set",         1'b0, 1'b1, 2'b10, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hA5, 1'b0);
      step("clear",       1'b0, 1'b1, 2'b11, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0);
      step("ld00",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // 6) Counting from 80, then reset together with a LOAD: the load must not apply.
      step("ld80",        1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h80, 8'h80, 8'h80, 1'b0);
      step("cnt_81",      1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 8'h00, 8'h81, 8'h01, 1'b0);
      step("rst_vs_ld",   1'b1, 1'b1, 2'b01, 1'b1, 8'hFF, 8'h11, 8'hA5, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
